// File: rtl/alu_issue_arbiter.sv
// Two-slot round-robin issue arbiter in front of a shared combinational ALU, with a one-deep result register.
// Optional usage counters are built only when ALU_ARB_STATS_EN is defined.
module alu_issue_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned TAG_W  = 3,
    localparam int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [CTRL_W-1:0] req1_ctrl,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [CTRL_W-1:0] alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_src,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_stall
);

    logic             prio;
    logic             slot_free_c;
    logic             grant0_c;
    logic             grant1_c;
    logic             grant_c;
    logic [TAG_W-1:0] grant_tag_c;

    assign slot_free_c = !out_valid || out_ready;
    assign grant_c     = grant0_c || grant1_c;
    assign req0_ready  = grant0_c;
    assign req1_ready  = grant1_c;

    // Grant selection; rst_n gating keeps both readies low during reset
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (rst_n && slot_free_c) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0_c = 1'b1;
            end else if (req1_valid) begin
                grant1_c = 1'b1;
            end
        end
    end

    // Steer the granted slot onto the shared ALU
    always_comb begin
        alu_a       = '0;
        alu_b       = '0;
        alu_ctrl    = '0;
        grant_tag_c = '0;
        if (grant0_c) begin
            alu_a       = req0_a;
            alu_b       = req0_b;
            alu_ctrl    = req0_ctrl;
            grant_tag_c = req0_tag;
        end else if (grant1_c) begin
            alu_a       = req1_a;
            alu_b       = req1_b;
            alu_ctrl    = req1_ctrl;
            grant_tag_c = req1_tag;
        end
    end

    // Result register: a grant loads (or replaces), an idle drain clears valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_tag    <= '0;
            out_src    <= 1'b0;
        end else if (grant_c) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_zero   <= alu_zero;
            out_tag    <= grant_tag_c;
            out_src    <= grant1_c;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Priority moves to the slot that lost (or did not take) the last grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (grant_c) begin
            prio <= grant0_c;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [STAT_W-1:0] cnt_grant0;
    logic [STAT_W-1:0] cnt_grant1;
    logic [STAT_W-1:0] cnt_stall;
    logic              stall_c;

    assign stall_c = (req0_valid || req1_valid) && !grant_c;

    // Saturating usage counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_grant0 <= '0;
            cnt_grant1 <= '0;
            cnt_stall  <= '0;
        end else begin
            if (grant0_c && (cnt_grant0 != '1)) cnt_grant0 <= cnt_grant0 + STAT_W'(1);
            if (grant1_c && (cnt_grant1 != '1)) cnt_grant1 <= cnt_grant1 + STAT_W'(1);
            if (stall_c && (cnt_stall != '1))   cnt_stall  <= cnt_stall + STAT_W'(1);
        end
    end

    assign stat_grant0 = cnt_grant0;
    assign stat_grant1 = cnt_grant1;
    assign stat_stall  = cnt_stall;
`else
    assign stat_grant0 = '0;
    assign stat_grant1 = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Scoreboard bench for alu_issue_arbiter with a small behavioural ALU; stats checks follow ALU_ARB_STATS_EN.
module tb_alu_issue_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;
    localparam int unsigned TAG_W  = 3;

    localparam logic [CTRL_W-1:0] OP_ADD = 4'd0;
    localparam logic [CTRL_W-1:0] OP_SUB = 4'd1;
    localparam logic [CTRL_W-1:0] OP_AND = 4'd2;
    localparam logic [CTRL_W-1:0] OP_OR  = 4'd3;
    localparam logic [CTRL_W-1:0] OP_XOR = 4'd4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic [TAG_W-1:0]  req0_tag, req1_tag;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [CTRL_W-1:0] alu_ctrl;
    logic              alu_zero;
    logic              out_valid, out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;
    logic              out_src;
    logic [15:0]       stat_grant0, stat_grant1, stat_stall;

    typedef struct {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic [TAG_W-1:0]  tag;
        logic              src;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    alu_issue_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_tag(out_tag), .out_src(out_src),
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_stall(stat_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        case (alu_ctrl)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_AND:  alu_result = alu_a & alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops and compares one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_output", 32'(out_result), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("out_result", 32'(out_result), 32'(e.result));
                check("out_zero",   32'(out_zero),   32'(e.zero));
                check("out_tag",    32'(out_tag),    32'(e.tag));
                check("out_src",    32'(out_src),    32'(e.src));
            end
        end
    end

    // One cycle: check readies mid-cycle, queue the expected result, advance past the edge
    task automatic step(input logic eg0, input logic eg1, input logic [DATA_W-1:0] eres, input logic ez);
        exp_t e;
        @(negedge clk);
        check("req0_ready", 32'(req0_ready), 32'(eg0));
        check("req1_ready", 32'(req1_ready), 32'(eg1));
        if (eg0 || eg1) begin
            e.result = eres;
            e.zero   = ez;
            e.tag    = eg1 ? req1_tag : req0_tag;
            e.src    = eg1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_ctrl = OP_ADD; req0_tag = 3'd2;
        req1_valid = 1'b1; req1_a = '0;    req1_b = '0;    req1_ctrl = OP_ADD; req1_tag = 3'd0;
        #3;
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_out_tag",    32'(out_tag),    32'd0);
        check("rst_out_src",    32'(out_src),    32'd0);
        check("rst_stat_stall", 32'(stat_stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        req1_valid = 1'b0;

        // Single request: 5 + 7, tag 2
        step(1'b1, 1'b0, 32'd12, 1'b0);
        req0_valid = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);

        // Both valid after reset: grants alternate 0,1,0,1
        do_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd3; req0_ctrl = OP_SUB; req0_tag = 3'd1;
        req1_valid = 1'b1; req1_a = 32'd6;  req1_b = 32'd9; req1_ctrl = OP_ADD; req1_tag = 3'd5;
        step(1'b1, 1'b0, 32'd7, 1'b0);
        req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = OP_OR; req0_tag = 3'd3;
        step(1'b0, 1'b1, 32'd15, 1'b0);
        step(1'b1, 1'b0, 32'd3, 1'b0);
        req1_a = 32'hF0; req1_b = 32'h3C; req1_ctrl = OP_AND; req1_tag = 3'd6;
        step(1'b0, 1'b1, 32'h30, 1'b0);
`ifdef ALU_ARB_STATS_EN
        check("stat_grant0_alt", 32'(stat_grant0), 32'd2);
        check("stat_grant1_alt", 32'(stat_grant1), 32'd2);
`endif
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);

        // Backpressure: result held three cycles with both slots waiting
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd8; req0_b = 32'd8; req0_ctrl = OP_ADD; req0_tag = 3'd3;
        step(1'b1, 1'b0, 32'd16, 1'b0);
        req0_a = 32'd3;   req0_b = 32'd3; req0_ctrl = OP_SUB; req0_tag = 3'd6;
        req1_valid = 1'b1;
        req1_a = 32'd100; req1_b = 32'd1; req1_ctrl = OP_SUB; req1_tag = 3'd7;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            check("hold_out_valid",  32'(out_valid),  32'd1);
            check("hold_out_result", 32'(out_result), 32'd16);
            check("hold_out_tag",    32'(out_tag),    32'd3);
            check("hold_out_src",    32'(out_src),    32'd0);
        end
`ifdef ALU_ARB_STATS_EN
        check("stat_stall_3", 32'(stat_stall), 32'd3);
`endif
        out_ready = 1'b1;
        step(1'b0, 1'b1, 32'd99, 1'b0);
        check("replace_out_valid", 32'(out_valid), 32'd1);
        req1_valid = 1'b0;
        // 3 - 3 gives zero
        step(1'b1, 1'b0, 32'd0, 1'b1);
        req0_valid = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);

        // Reset mid-cycle with a held result; priority must return to slot 0
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_ctrl = OP_ADD; req0_tag = 3'd4;
        step(1'b1, 1'b0, 32'd2, 1'b0);
        req0_valid = 1'b0;
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid",  32'(out_valid),  32'd0);
        check("midrst_out_result", 32'(out_result), 32'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            check("post_rst_idle_valid", 32'(out_valid), 32'd0);
        end
        req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd4; req0_ctrl = OP_SUB; req0_tag = 3'd1;
        req1_valid = 1'b1; req1_a = 32'd2; req1_b = 32'd2; req1_ctrl = OP_ADD; req1_tag = 3'd2;
        step(1'b1, 1'b0, 32'd5, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step(1'b0, 1'b0, '0, 1'b0);

        // Long stall: counter saturation (stats build) or tied-off ports
        out_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = OP_ADD; req0_tag = 3'd5;
        step(1'b1, 1'b0, 32'd3, 1'b0);
`ifdef ALU_ARB_STATS_EN
        repeat (65540) @(posedge clk);
        #1;
        check("stat_stall_sat", 32'(stat_stall), 32'h0000_FFFF);
`else
        repeat (20) @(posedge clk);
        #1;
        check("stat_grant0_off", 32'(stat_grant0), 32'd0);
        check("stat_grant1_off", 32'(stat_grant1), 32'd0);
        check("stat_stall_off",  32'(stat_stall),  32'd0);
`endif
        req0_valid = 1'b0;
        out_ready = 1'b1;
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);

        check("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
